// File: rtl/trig_window_integrator.sv
// Triggered window integrator: after each trigger edge, waits a latched delay,
// then sums a latched number of signed samples and presents the total with a
// one-cycle valid strobe. Triggers arriving while busy set a sticky miss flag.
module trig_window_integrator #(
  parameter int DIN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trig,
  input  logic signed [DIN_W-1:0]        din,
  input  logic        [CNT_W-1:0]        delay,
  input  logic        [CNT_W-1:0]        width,
  input  logic                           miss_clr,
  output logic                           busy,
  output logic                           sum_valid,
  output logic signed [DIN_W+CNT_W-1:0]  sum_out,
  output logic                           trig_miss
);

  localparam int SUM_W = DIN_W + CNT_W;

  typedef enum logic [1:0] {IDLE, DELAY, INTEG, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     trig_a_q, trig_b_q;
  logic                     trig_edge;
  logic [CNT_W-1:0]         d_cnt_q, d_cnt_d;
  logic [CNT_W-1:0]         w_cnt_q, w_cnt_d;
  logic signed [SUM_W-1:0]  acc_q, acc_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic                     valid_q, valid_d;
  logic                     miss_q, miss_d;

  // Widen a sample to accumulator width; the accumulator holds 2^CNT_W-1
  // full-scale samples, so no saturation is ever needed.
  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DIN_W-1:0] x);
    return {{CNT_W{x[DIN_W-1]}}, x};
  endfunction

  assign trig_edge = trig_a_q & ~trig_b_q;
  assign busy      = (state_q != IDLE);
  assign sum_valid = valid_q;
  assign sum_out   = sum_q;
  assign trig_miss = miss_q;

  // Trigger synchroniser/edge detector and all state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_a_q <= 1'b0;
      trig_b_q <= 1'b0;
      state_q  <= IDLE;
      d_cnt_q  <= '0;
      w_cnt_q  <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      trig_a_q <= trig;
      trig_b_q <= trig_a_q;
      state_q  <= state_d;
      d_cnt_q  <= d_cnt_d;
      w_cnt_q  <= w_cnt_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
      miss_q   <= miss_d;
    end
  end

  // Window sequencing, accumulation and miss-flag next-state logic.
  always_comb begin
    state_d = state_q;
    d_cnt_d = d_cnt_q;
    w_cnt_d = w_cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    miss_d  = miss_q;

    unique case (state_q)
      IDLE: begin
        if (trig_edge) begin
          d_cnt_d = delay;
          w_cnt_d = width;
          acc_d   = '0;
          if (delay != '0)      state_d = DELAY;
          else if (width != '0) state_d = INTEG;
          else                  state_d = DONE;
        end
      end
      DELAY: begin
        d_cnt_d = d_cnt_q - 1'b1;
        if (d_cnt_q == CNT_W'(1)) state_d = (w_cnt_q != '0) ? INTEG : DONE;
      end
      INTEG: begin
        acc_d   = acc_q + sext(din);
        w_cnt_d = w_cnt_q - 1'b1;
        if (w_cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        sum_d   = acc_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new miss takes priority over a concurrent clear.
    if (trig_edge && busy) miss_d = 1'b1;
    else if (miss_clr)     miss_d = 1'b0;
  end

endmodule

// File: tb/tb_trig_window_integrator.sv
// Directed bench for trig_window_integrator with hand-computed sums/latencies.
// Latency is counted in clock edges from the cycle trig is raised to the
// first cycle sum_valid is seen: D + W + 3.
module tb_trig_window_integrator;

  logic               clk = 1'b0;
  logic               rst;
  logic               trig;
  logic signed [15:0] din;
  logic        [7:0]  delay;
  logic        [7:0]  width;
  logic               miss_clr;
  logic               busy;
  logic               sum_valid;
  logic signed [23:0] sum_out;
  logic               trig_miss;

  int n_vec = 0;
  int n_err = 0;

  trig_window_integrator #(.DIN_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .din       (din),
    .delay     (delay),
    .width     (width),
    .miss_clr  (miss_clr),
    .busy      (busy),
    .sum_valid (sum_valid),
    .sum_out   (sum_out),
    .trig_miss (trig_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fire one window and observe it. Optional hooks: re-raise trig at cycle
  // retrig_at, change delay/width to 9 at cycle chg_at, drive a din ramp.
  task automatic run_win(input string tag, input int d, input int w,
                         input longint exp_sum, input int retrig_at,
                         input int chg_at, input bit ramp);
    int exp_lat;
    int lat;
    int pulses;
    logic signed [23:0] sv;
    exp_lat = d + w + 3;
    lat     = 0;
    pulses  = 0;
    sv      = '0;
    delay   = 8'(d);
    width   = 8'(w);
    trig    = 1'b1;
    if (ramp) din = 16'sd0;
    for (int c = 1; c <= exp_lat + 6; c++) begin
      step();
      if (ramp) din = 16'(c);
      if (sum_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          sv  = sum_out;
        end
      end
      if (c == 2) trig = 1'b0;
      if (c == retrig_at) trig = 1'b1;
      if (c == retrig_at + 2) trig = 1'b0;
      if (c == chg_at) begin
        delay = 8'd9;
        width = 8'd9;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_sum"}, sv, exp_sum);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_hold"}, sum_out, exp_sum);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; trig = 1'b0; din = '0; delay = '0; width = '0; miss_clr = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_miss", trig_miss, 0);
    step();
    rst = 1'b0;
    step();

    // Constant +100, delay 3, width 10.
    din = 16'sd100;
    run_win("t1", 3, 10, 1000, 0, 0, 1'b0);

    // Full-scale negative, maximum width: -32768 * 255.
    din = -16'sd32768;
    run_win("t2", 0, 255, -8355840, 0, 0, 1'b0);
    chk("t2_hex", sum_out[23:0], 24'h808000);

    // Zero width yields a zero result after the delay.
    din = 16'sd55;
    run_win("t3", 5, 0, 0, 0, 0, 1'b0);
    run_win("t3b", 0, 0, 0, 0, 0, 1'b0);
    chk("miss_idle", trig_miss, 0);

    // Retrigger mid-window: result unaffected, miss set; then clear it.
    din = 16'sd100;
    run_win("t4", 3, 10, 1000, 5, 0, 1'b0);
    chk("t4_miss_set", trig_miss, 1);
    miss_clr = 1'b1;
    step();
    miss_clr = 1'b0;
    chk("t4_miss_clr", trig_miss, 0);

    // Miss and clear on the same edge: the set wins.
    delay = 8'd3; width = 8'd10; trig = 1'b1;
    step(); step();
    trig = 1'b0;
    step(); step();
    trig = 1'b1;
    step();
    miss_clr = 1'b1;
    step();
    chk("t4_miss_vs_clr", trig_miss, 1);
    miss_clr = 1'b0;
    trig = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("t4_back_idle", busy, 0);

    // Async reset in the middle of integration.
    din = 16'sd3;
    delay = 8'd0; width = 8'd20; trig = 1'b1;
    step(); step();
    trig = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", sum_valid, 0);
    chk("t5_rst_sum", sum_out, 0);
    chk("t5_rst_miss", trig_miss, 0);
    step(); step();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sum_valid) vcnt++;
    end
    chk("t5_no_partial", vcnt, 0);
    din = 16'sd7;
    run_win("t5_after", 1, 3, 21, 0, 0, 1'b0);

    // Ramp, delay 2, width 4: samples 4,5,6,7; delay/width changed mid-window.
    run_win("t6", 2, 4, 22, 0, 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
